// File: rtl/mul_seq_ctrl.sv
// Sequential signed 32x32 multiplier: radix-4 Booth, one digit per clock into a 64-bit accumulator.
// Latency 16 CALC cycles (1..16 with MUL_SEQ_EARLY_EXIT_EN), done pulses one cycle, result in hi/lo.
// No backpressure: start is only sampled in IDLE and never queued; requester waits for busy to fall.
module mul_seq_ctrl #(
  parameter int DIGITS = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] M,
  input  logic [31:0] Q,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int JW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [JW-1:0] JLAST = JW'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [31:0]   mreg;
  logic [31:0]   qreg;
  logic [63:0]   acc;
  logic [JW-1:0] j;

  logic [32:0]   qext;
  logic [JW:0]   shamt;
  logic [2:0]    grp;
  logic [63:0]   m64;
  logic [63:0]   pp;
  logic [63:0]   acc_next;
  logic          finish;
`ifdef MUL_SEQ_EARLY_EXIT_EN
  logic [31:0]   qrest;
`endif

  always_comb begin
    // Q[-1] = 0 is supplied by the appended zero bit
    qext  = {qreg, 1'b0};
    shamt = {j, 1'b0};
    grp   = qext[shamt +: 3];
    m64   = {{32{mreg[31]}}, mreg};
    case (grp)
      3'b001, 3'b010: pp = m64;
      3'b011:         pp = m64 << 1;
      3'b100:         pp = -(m64 << 1);
      3'b101, 3'b110: pp = -m64;
      default:        pp = '0;
    endcase
    acc_next = acc + (pp << shamt);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    // remaining digits are all zero once Q[31:2j+1] is a pure sign run
    qrest  = $signed(qreg) >>> {j, 1'b1};
    finish = (j == JLAST) || (qrest == 32'h0) || (qrest == 32'hFFFF_FFFF);
`else
    finish = (j == JLAST);
`endif
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      mreg  <= '0;
      qreg  <= '0;
      acc   <= '0;
      j     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mreg  <= M;
            qreg  <= Q;
            acc   <= '0;
            j     <= '0;
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_next;
          j   <= j + 1'b1;
          if (finish) begin
            state <= DONE;
            hi    <= acc_next[63:32];
            lo    <= acc_next[31:0];
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
